display_scan_controller: RTL

//  Time-multiplexes NUM_DIGITS seven-segment digits onto one shared segment bus.

---
 rtl/display_pkg.sv | 33 +++
 rtl/hex_to_sseg.sv | 22 ++
 rtl/display_scan_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// ============================================================================
// Module : display_pkg
// Brief  : Scan-state encoding, digit width, and segment constants shared by
//          the display scan controller. Macro: SEG_HEX_DECODE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

`ifdef SEG_HEX_DECODE_EN
  localparam int DIGIT_W = 4;
`else
  localparam int DIGIT_W = 7;
`endif

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
  localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/hex_to_sseg.sv
// ============================================================================
// Module : hex_to_sseg
// Brief  : Combinational 4-bit hex to active-low seven-segment decoder.
//          Only present when SEG_HEX_DECODE_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifdef SEG_HEX_DECODE_EN
module hex_to_sseg
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[hex];

endmodule
`endif

`default_nettype wire

// File: rtl/display_scan_controller.sv
// ============================================================================
// Module : display_scan_controller
// Brief  : Multiplexes NUM_DIGITS seven-segment digits with anode blanking,
//          per-frame snapshot and blink. Macro: SEG_HEX_DECODE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
)
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick_refresh,
  input  logic                          tick_blink,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic                          frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  scan_state_t                   r_state;
  logic [IDX_W-1:0]              r_idx;
  logic [CNT_W-1:0]              r_blank_cnt;
  logic                          r_blink_phase;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_snap_digits;
  logic [NUM_DIGITS-1:0]         r_snap_dp;
  logic [NUM_DIGITS-1:0]         r_snap_mask;

  logic [DIGIT_W-1:0]            w_cur_raw;
  logic [6:0]                    w_cur_seg;
  logic [NUM_DIGITS-1:0]         w_an_sel;

  assign w_cur_raw = r_snap_digits[r_idx*DIGIT_W +: DIGIT_W];
  assign w_an_sel  = ~(NUM_DIGITS'(1) << r_idx);

`ifdef SEG_HEX_DECODE_EN
  hex_to_sseg u_hex_to_sseg (
    .hex (w_cur_raw),
    .seg (w_cur_seg)
  );
`else
  assign w_cur_seg = w_cur_raw;
`endif

  // Outputs are registered from the current state, so pins lag the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_LOAD;
      r_idx         <= '0;
      r_blank_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
      r_snap_mask   <= '0;
      an            <= '1;
      seg           <= SEG_OFF;
      dp            <= 1'b1;
      frame_start   <= 1'b0;
    end else begin
      if (tick_blink) r_blink_phase <= ~r_blink_phase;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_snap_digits <= digits;
          r_snap_dp     <= dp_in;
          r_snap_mask   <= blink_mask;
          frame_start   <= 1'b1;
          r_idx         <= '0;
          r_blank_cnt   <= '0;
          r_state       <= (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        end
        ST_BLANK: begin
          if (r_blank_cnt == LAST_CNT) r_state <= ST_DRIVE;
          else                         r_blank_cnt <= r_blank_cnt + 1'b1;
        end
        ST_DRIVE: begin
          if (!(r_snap_mask[r_idx] && r_blink_phase)) begin
            an  <= w_an_sel;
            seg <= w_cur_seg;
            dp  <= ~r_snap_dp[r_idx];
          end
          if (tick_refresh) begin
            if (r_idx == LAST_IDX) begin
              r_state <= ST_LOAD;
            end else begin
              r_idx       <= r_idx + 1'b1;
              r_blank_cnt <= '0;
              r_state     <= (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

`default_nettype wire
